// File: rtl/fuzz_ctrl_pkg.sv
// Shared types for the fuzz round controller: FSM state encoding, round result
// codes and counter widths.
package fuzz_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_PASS    = 2'd1,
    RES_TIMEOUT = 2'd2
  } result_t;

  localparam int CNT_W = 24;
  localparam int CYC_W = 64;

endpackage

// File: rtl/fuzz_stall_mon.sv
// Coverage-stall and tohost watchdog monitor; raises the software interrupt
// when coverage stops moving or the DUT goes quiet for too long.
module fuzz_stall_mon import fuzz_ctrl_pkg::*; #(
  parameter int COV_W      = 30,
  parameter int MAX_WAIT   = 1000,
  parameter int WDOG_LIMIT = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic             run_next,
  input  logic             pass,
  input  logic [COV_W-1:0] cov,
  output logic             interrupt
);

  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_LIMIT);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0] thresh;
  logic [COV_W-1:0] cov_prev_q;
  logic             irq_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Threshold scales with coverage magnitude; the product wraps at counter width.
  always_comb begin
    thresh = CNT_W'(MAX_WAIT) * (CNT_W'(cov >> 19) + CNT_W'(1));
    stall_d = stall_q;
    wdog_d  = wdog_q;
    if (run) begin
      stall_d = (cov != cov_prev_q) ? '0 : sat_inc(stall_q);
      wdog_d  = pass ? '0 : sat_inc(wdog_q);
    end
    irq_d = run_next && ((stall_d >= thresh) || (wdog_d >= WDOG_LIM));
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      stall_q    <= '0;
      wdog_q     <= '0;
      cov_prev_q <= '0;
      interrupt  <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      wdog_q    <= wdog_d;
      interrupt <= irq_d;
      if (run) cov_prev_q <= cov;
    end
  end

endmodule

// File: rtl/fuzz_round_ctrl.sv
// Fuzzing round sequencer: holds the DUT in reset, runs it until pass or
// timeout, hands the coverage snapshot to the host, then reloads or stops.
module fuzz_round_ctrl import fuzz_ctrl_pkg::*; #(
  parameter int COV_W      = 30,
  parameter int MAX_CYCLES = 200000,
  parameter int MAX_WAIT   = 1000,
  parameter int WDOG_LIMIT = 50000,
  parameter int RST_HOLD   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      tohost,
  input  logic [COV_W-1:0] cov,
  input  logic             cov_ack,
  input  logic             cov_cont,
  input  logic             load_done,
  output logic             dut_reset,
  output logic             clk_en,
  output logic             interrupt,
  output logic             cov_req,
  output logic [COV_W-1:0] cov_snap,
  output logic [1:0]       result,
  output logic             load_req,
  output logic             busy
);

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX   = CYC_W'(MAX_CYCLES);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [CYC_W-1:0]   cyc_q, cyc_inc;
  result_t            res_q;
  logic [COV_W-1:0]   snap_q;
  logic               pass, timeout;
  logic               hold_entry, halt_entry;
  logic               unused_tohost;

  assign unused_tohost = ^tohost[63:1];

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cyc_inc   = cyc_q + CYC_W'(1);
    pass      = 1'b0;
    timeout   = 1'b0;
    dut_reset = 1'b1;
    clk_en    = 1'b0;
    cov_req   = 1'b0;
    load_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_HOLD;
      ST_HOLD: begin
        clk_en = 1'b1;
        if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        dut_reset = 1'b0;
        clk_en    = 1'b1;
        pass      = tohost[0];
        timeout   = cyc_inc > CYC_MAX;
        if (pass || timeout) state_d = ST_HALT;
      end
      ST_HALT: begin
        dut_reset = 1'b0;
        cov_req   = 1'b1;
        if (cov_ack) state_d = cov_cont ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        load_req = 1'b1;
        if (load_done) state_d = ST_HOLD;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign hold_entry = (state_d == ST_HOLD) && (state_q != ST_HOLD);
  assign halt_entry = (state_d == ST_HALT) && (state_q == ST_RUN);

  // Round bookkeeping: hold timer, cycle counter, result and coverage snapshot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_cnt_q <= '0;
      cyc_q      <= '0;
      res_q      <= RES_NONE;
      snap_q     <= '0;
    end else begin
      if (hold_entry) begin
        hold_cnt_q <= '0;
        cyc_q      <= '0;
        res_q      <= RES_NONE;
      end else begin
        if (state_q == ST_HOLD) hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        if (state_q == ST_RUN)  cyc_q      <= cyc_inc;
      end
      if (halt_entry) begin
        res_q  <= pass ? RES_PASS : RES_TIMEOUT;
        snap_q <= cov;
      end
    end
  end

  assign result   = res_q;
  assign cov_snap = snap_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);

  fuzz_stall_mon #(
    .COV_W      (COV_W),
    .MAX_WAIT   (MAX_WAIT),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_stall_mon (
    .clock     (clock),
    .reset     (reset),
    .clear     (hold_entry),
    .run       (state_q == ST_RUN),
    .run_next  (state_d == ST_RUN),
    .pass      (tohost[0]),
    .cov       (cov),
    .interrupt (interrupt)
  );

endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// Table-driven bench for fuzz_round_ctrl: a short-budget instance for timeout,
// stall, watchdog, loop and reset cases, and a default instance for a long pass.
module tb_fuzz_round_ctrl;

  localparam int COV_W = 30;

  typedef struct packed {
    logic             dut_reset;
    logic             clk_en;
    logic             interrupt;
    logic             cov_req;
    logic [1:0]       result;
    logic             load_req;
    logic             busy;
    logic [COV_W-1:0] cov_snap;
  } obs_t;

  typedef struct {
    logic             rst_n;
    logic             st;
    logic             th;
    logic [COV_W-1:0] cv;
    logic             ack;
    logic             cont;
    logic             ld;
    int               n;
    obs_t             exp;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset, start, cov_ack, cov_cont, load_done;
  logic [63:0]      tohost;
  logic [COV_W-1:0] cov;

  logic             a_dut_reset, a_clk_en, a_interrupt, a_cov_req, a_load_req, a_busy;
  logic [1:0]       a_result;
  logic [COV_W-1:0] a_cov_snap;
  logic             b_dut_reset, b_clk_en, b_interrupt, b_cov_req, b_load_req, b_busy;
  logic [1:0]       b_result;
  logic [COV_W-1:0] b_cov_snap;
  obs_t             act_a, act_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  vec_t vecs[$];

  always #5 clock = ~clock;

  fuzz_round_ctrl #(
    .COV_W(COV_W), .MAX_CYCLES(100), .MAX_WAIT(10), .WDOG_LIMIT(40), .RST_HOLD(8)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .tohost(tohost), .cov(cov),
    .cov_ack(cov_ack), .cov_cont(cov_cont), .load_done(load_done),
    .dut_reset(a_dut_reset), .clk_en(a_clk_en), .interrupt(a_interrupt),
    .cov_req(a_cov_req), .cov_snap(a_cov_snap), .result(a_result),
    .load_req(a_load_req), .busy(a_busy)
  );

  fuzz_round_ctrl u_dflt (
    .clock(clock), .reset(reset), .start(start), .tohost(tohost), .cov(cov),
    .cov_ack(cov_ack), .cov_cont(cov_cont), .load_done(load_done),
    .dut_reset(b_dut_reset), .clk_en(b_clk_en), .interrupt(b_interrupt),
    .cov_req(b_cov_req), .cov_snap(b_cov_snap), .result(b_result),
    .load_req(b_load_req), .busy(b_busy)
  );

  assign act_a = {a_dut_reset, a_clk_en, a_interrupt, a_cov_req, a_result, a_load_req, a_busy, a_cov_snap};
  assign act_b = {b_dut_reset, b_clk_en, b_interrupt, b_cov_req, b_result, b_load_req, b_busy, b_cov_snap};

  function automatic vec_t mk_vec(input logic rst_n, input logic st, input logic th,
                                  input logic [COV_W-1:0] cv, input logic ack, input logic cont,
                                  input logic ld, input int n, input logic dr, input logic ce,
                                  input logic irq, input logic req, input logic [1:0] res,
                                  input logic lr, input logic bsy, input logic [COV_W-1:0] snap);
    vec_t v;
    v.rst_n = rst_n; v.st = st; v.th = th; v.cv = cv;
    v.ack = ack; v.cont = cont; v.ld = ld; v.n = n;
    v.exp.dut_reset = dr; v.exp.clk_en = ce; v.exp.interrupt = irq; v.exp.cov_req = req;
    v.exp.result = res; v.exp.load_req = lr; v.exp.busy = bsy; v.exp.cov_snap = snap;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input obs_t act);
    obs_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got dr=%b ce=%b irq=%b req=%b res=%0d lr=%b busy=%b snap=%h, expected dr=%b ce=%b irq=%b req=%b res=%0d lr=%b busy=%b snap=%h",
                 tag, act.dut_reset, act.clk_en, act.interrupt, act.cov_req, act.result,
                 act.load_req, act.busy, act.cov_snap, e.dut_reset, e.clk_en, e.interrupt,
                 e.cov_req, e.result, e.load_req, e.busy, e.cov_snap);
      end
    end
  endtask

  task automatic run_step(input vec_t v, input bit on_dflt, input string tag);
    reset     = v.rst_n;
    start     = v.st;
    tohost    = {32'hDEADBEEF, 31'd0, v.th};
    cov       = v.cv;
    cov_ack   = v.ack;
    cov_cont  = v.cont;
    load_done = v.ld;
    exp_q.push_back(v.exp);
    tick(v.n);
    check(tag, on_dflt ? act_b : act_a);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; tohost = '0; cov = '0;
    cov_ack = 1'b0; cov_cont = 1'b0; load_done = 1'b0;

    //                 rst st th cov         ack cont ld  n    dr ce irq req res  lr bsy snap
    vecs.push_back(mk_vec(0, 0, 0, 30'h5,      0, 0, 0,  3,   1, 0, 0, 0, 2'd0, 0, 0, 30'h0));
    vecs.push_back(mk_vec(1, 1, 0, 30'h5,      0, 0, 0,  1,   1, 1, 0, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 0,  7,   1, 1, 0, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 0,  1,   0, 1, 0, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 0, 10,   0, 1, 0, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 0,  1,   0, 1, 1, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 0, 89,   0, 1, 1, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 0,  1,   0, 0, 0, 1, 2'd2, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 1,  3,   0, 0, 0, 1, 2'd2, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      1, 1, 0,  1,   1, 0, 0, 0, 2'd2, 1, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      1, 0, 0,  2,   1, 0, 0, 0, 2'd2, 1, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h5,      0, 0, 1,  1,   1, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80000,  0, 0, 0,  7,   1, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80000,  0, 0, 0,  1,   0, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80000,  0, 0, 0, 20,   0, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80000,  0, 0, 0,  1,   0, 1, 1, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80001,  0, 0, 0,  1,   0, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80001,  0, 0, 0,  1,   0, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80001,  0, 0, 0, 16,   0, 1, 0, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80001,  0, 0, 0,  1,   0, 1, 1, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80001,  0, 0, 0, 60,   0, 1, 1, 0, 2'd0, 0, 1, 30'h5));
    vecs.push_back(mk_vec(1, 0, 1, 30'h80001,  0, 0, 0,  1,   0, 0, 0, 1, 2'd1, 0, 1, 30'h80001));
    vecs.push_back(mk_vec(1, 0, 0, 30'h80001,  1, 0, 0,  1,   1, 0, 0, 0, 2'd1, 0, 0, 30'h80001));
    vecs.push_back(mk_vec(1, 1, 0, 30'h80001,  0, 0, 1,  3,   1, 0, 0, 0, 2'd1, 0, 0, 30'h80001));
    vecs.push_back(mk_vec(0, 0, 0, 30'h80001,  0, 0, 0,  1,   1, 0, 0, 0, 2'd0, 0, 0, 30'h0));
    vecs.push_back(mk_vec(1, 0, 1, 30'h80001,  1, 1, 1,  3,   1, 0, 0, 0, 2'd0, 0, 0, 30'h0));
    vecs.push_back(mk_vec(1, 1, 0, 30'h0,      0, 0, 0,  1,   1, 1, 0, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h0,      0, 0, 0, 29,   0, 1, 1, 0, 2'd0, 0, 1, 30'h0));
    vecs.push_back(mk_vec(0, 0, 0, 30'h0,      0, 0, 0,  1,   1, 0, 0, 0, 2'd0, 0, 0, 30'h0));
    vecs.push_back(mk_vec(1, 0, 0, 30'h0,      0, 0, 0,  2,   1, 0, 0, 0, 2'd0, 0, 0, 30'h0));

    for (int i = 0; i < vecs.size(); i++)
      run_step(vecs[i], 1'b0, $sformatf("row%0d", i));

    // Long round on the default-budget instance: pass at RUN cycle 500.
    run_step(mk_vec(1, 1, 0, 30'h3, 0, 0, 0,   1, 1, 1, 0, 0, 2'd0, 0, 1, 30'h0), 1'b1, "pass_hold");
    run_step(mk_vec(1, 0, 0, 30'h3, 0, 0, 0, 507, 0, 1, 0, 0, 2'd0, 0, 1, 30'h0), 1'b1, "pass_run500");
    run_step(mk_vec(1, 0, 1, 30'h3, 0, 0, 0,   1, 0, 0, 0, 1, 2'd1, 0, 1, 30'h3), 1'b1, "pass_halt");
    run_step(mk_vec(1, 0, 0, 30'h3, 1, 0, 0,   1, 1, 0, 0, 0, 2'd1, 0, 0, 30'h3), 1'b1, "pass_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_round_ctrl.md
FUZZ_ROUND_CTRL -- requirements
Module: fuzz_round_ctrl

Interface
REQ-001 SHALL have parameter COV_W, default 30, coverage-sum width.
REQ-002 SHALL have parameter MAX_CYCLES, default 200000, per-round cycle budget before timeout.
REQ-003 SHALL have parameter MAX_WAIT, default 1000, base coverage-stall threshold in cycles.
REQ-004 SHALL have parameter WDOG_LIMIT, default 50000, cycles without tohost pass before interrupt.
REQ-005 SHALL have parameter RST_HOLD, default 8, DUT reset assertion length in cycles.
REQ-006 SHALL have ports, one per line: name, direction, width, meaning:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins the first round from IDLE.
- tohost  in  64  DUT tohost word; bit 0 = round finished.
- cov  in  COV_W  DUT coverage sum.
- cov_ack  in  1  host collector done with snapshot.
- cov_cont  in  1  sampled with cov_ack; 1 = run another round.
- load_done  in  1  testcase reload complete.
- dut_reset  out  1  active-high DUT reset.
- clk_en  out  1  DUT clock enable.
- interrupt  out  1  software-interrupt injection to DUT.
- cov_req  out  1  snapshot valid, request to collector.
- cov_snap  out  COV_W  coverage captured at round end.
- result  out  2  0 none, 1 pass, 2 timeout.
- load_req  out  1  request testcase reload.
- busy  out  1  high in any state except IDLE and DONE.

Function
REQ-007 SHALL implement states IDLE, HOLD, RUN, HALT, LOAD, DONE.
REQ-008 IDLE SHALL go to HOLD on start; all other inputs are ignored in IDLE.
REQ-009 HOLD SHALL drive dut_reset=1 and clk_en=1 for exactly RST_HOLD cycles, then enter RUN.
REQ-010 RUN SHALL drive dut_reset=0 and clk_en=1, and SHALL increment a 64-bit round cycle counter each cycle.
REQ-011 In RUN, tohost[0]=1 SHALL move to HALT with result=1 on the next edge.
REQ-012 In RUN, round counter > MAX_CYCLES SHALL move to HALT with result=2.
REQ-013 If pass and timeout occur in the same cycle, pass SHALL win.
REQ-014 On entering HALT, cov SHALL be captured into cov_snap.
REQ-015 HALT SHALL drive clk_en=0 and cov_req=1 until cov_ack is sampled high.
REQ-016 On cov_ack, cov_cont=1 SHALL go to LOAD and cov_cont=0 SHALL go to DONE.
REQ-017 LOAD SHALL drive clk_en=0, dut_reset=1 and load_req=1 until load_done, then enter HOLD with the round counter cleared.
REQ-018 DONE SHALL be terminal: clk_en=0, dut_reset=1; only reset exits it.
REQ-019 Stall counter (24 bit, saturating) SHALL clear when cov differs from its registered previous value, else increment; it is active only in RUN.
REQ-020 Watchdog counter (24 bit, saturating) SHALL increment in RUN and clear on tohost[0]=1.
REQ-021 interrupt SHALL be registered and SHALL equal (stall >= MAX_WAIT*((cov>>19)+1)) OR (wdog >= WDOG_LIMIT); the product SHALL be computed at 24 bits.
REQ-022 Stall counter, watchdog, previous-cov register and interrupt SHALL clear on every HOLD entry.
REQ-023 interrupt SHALL be 0 outside RUN.
REQ-024 result SHALL hold its value until the next HOLD entry, where it clears to 0.
REQ-025 cov_ack while not in HALT and load_done while not in LOAD SHALL be ignored.

Reset
REQ-026 reset low at a clock edge SHALL force IDLE, dut_reset=1, clk_en=0, interrupt=0, cov_req=0, load_req=0, result=0, cov_snap=0, busy=0, and all counters to 0, including mid-round.

Structure
REQ-027 The state enum and result encoding SHALL be in shared package fuzz_ctrl_pkg.
REQ-028 Stall/watchdog logic SHALL be sub-module fuzz_stall_mon; FSM and cycle counter SHALL be in the top module.

Verification
REQ-029 Pass: start; tohost=1 at RUN cycle 500 -> HALT, result=1, cov_req=1, clk_en=0; cov_ack with cov_cont=0 -> DONE.
REQ-030 Timeout with MAX_CYCLES=100: tohost held at 0 -> HALT after 101 RUN cycles, result=2.
REQ-031 Stall with cov=0x80000 constant, MAX_WAIT=10: interrupt rises when stall reaches 20; a cov change clears it on the next cycle.
REQ-032 Loop: cov_ack with cov_cont=1 -> LOAD with load_req=1; load_done -> HOLD for 8 cycles with dut_reset=1, then RUN with result=0.
REQ-033 Reset low mid-RUN with interrupt=1 -> next edge IDLE with all outputs at reset values.
REQ-034 Simultaneous tohost=1 and timeout -> result=1.
